// File: rtl/ram_responder.sv
// Wait-state RAM responder: a FREE/BUSY/ACCESS/ERROR handshake in front of a
// word-addressed backing array, with a LAT-cycle wait before each access.
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module ram_responder #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ramREN,
    input  logic                     ramWEN,
    input  logic [31:0]              ramaddr,
    input  logic [31:0]              ramstore,
    output logic [31:0]              ramload,
    output cpu_types_pkg::ramstate_t ramstate
);
    import cpu_types_pkg::*;

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  RELOAD  = 4'(LAT - 1);

    ramstate_t     r_state;
    logic [3:0]    r_cnt;
    logic          r_op;
    logic [31:0]   r_addr;
    logic [31:0]   r_mem [DEPTH];

    logic          w_req;
    logic          w_valid;
    logic          w_illegal;
    logic          w_same;
    logic          w_access;
    logic [AW-1:0] w_idx;

    always_comb begin
        w_req     = ramREN | ramWEN;
        w_valid   = (ramREN ^ ramWEN) && (ramaddr[1:0] == 2'b00)
                    && ({2'b00, ramaddr[31:2]} < DEPTH_W);
        w_illegal = w_req && !w_valid;
        w_same    = w_valid && (ramWEN == r_op) && (ramaddr == r_addr);
        w_access  = !RST && (r_state == BUSY) && w_same && (r_cnt == '0);
        w_idx     = r_addr[AW+1:2];
    end

    always_ff @(posedge CLK) begin
        if (w_access && r_op) begin
            r_mem[w_idx] <= ramstore;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= FREE;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_addr  <= '0;
            ramload <= '0;
        end else begin
            case (r_state)
                BUSY: begin
                    if (!w_req) begin
                        r_state <= FREE;
                    end else if (w_illegal) begin
                        r_state <= ERROR;
                    end else if (!w_same) begin
                        r_op   <= ramWEN;
                        r_addr <= ramaddr;
                        r_cnt  <= RELOAD;
                    end else if (r_cnt == '0) begin
                        r_state <= ACCESS;
                        if (!r_op) begin
                            ramload <= r_mem[w_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                // FREE, ACCESS and ERROR all decode the incoming request identically
                default: begin
                    if (w_valid) begin
                        r_state <= BUSY;
                        r_op    <= ramWEN;
                        r_addr  <= ramaddr;
                        r_cnt   <= RELOAD;
                    end else if (w_illegal) begin
                        r_state <= ERROR;
                    end else begin
                        r_state <= FREE;
                    end
                end
            endcase
        end
    end

    assign ramstate = r_state;

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning wait-state cycles spent in BUSY before ACCESS (legal 1..15).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words in the backing array.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ramREN  input  1  read request from the memory controller.
REQ-006 SHALL have port ramWEN  input  1  write request from the memory controller.
REQ-007 SHALL have port ramaddr  input  32  byte address of the request.
REQ-008 SHALL have port ramstore  input  32  write data.
REQ-009 SHALL have port ramload  output  32  read data, registered.
REQ-010 SHALL have port ramstate  output  2  response state, encoded as ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.

Function
REQ-011 SHALL implement a four-state machine whose current state drives ramstate directly.
REQ-012 SHALL define the request as valid when exactly one of ramREN/ramWEN is high, ramaddr[1:0]==0, and ramaddr[31:2] < DEPTH.
REQ-013 SHALL treat the request as illegal when ramREN and ramWEN are both high, or when either is high with a misaligned or out-of-range address.
REQ-014 FREE: with no request, SHALL stay FREE; with a valid request, SHALL go BUSY and load the wait counter with LAT-1; with an illegal request, SHALL go ERROR.
REQ-015 BUSY: SHALL latch {op, address} on entry, and SHALL decrement the counter each cycle while the request is unchanged.
REQ-016 BUSY: when the counter is 0 and the request is unchanged, SHALL go ACCESS on the next edge.
REQ-017 BUSY: when the request drops, SHALL go FREE with no memory side effect.
REQ-018 BUSY: when the op or address changes to another valid request, SHALL stay BUSY, re-latch, and reload the counter with LAT-1 (restart).
REQ-019 BUSY: when the request becomes illegal, SHALL go ERROR.
REQ-020 SHALL perform the access on the edge that enters ACCESS: reads load ramload from mem[addr]; writes store ramstore into mem[addr].
REQ-021 ACCESS SHALL last exactly one cycle; the next state SHALL be BUSY (new access, counter LAT-1) if a valid request is present, ERROR if an illegal request is present, and FREE otherwise.
REQ-022 SHALL therefore complete a held request as back-to-back accesses, each taking LAT BUSY cycles plus 1 ACCESS cycle.
REQ-023 ERROR: SHALL stay in ERROR while the request is illegal, go FREE when the request drops, and go BUSY on a valid request.
REQ-024 ERROR SHALL never modify the array or ramload.
REQ-025 ramload SHALL hold its value outside ACCESS-entry edges; a write SHALL NOT update ramload.
REQ-026 A read issued after a write to the same address SHALL return the newly written data.
REQ-027 The wait counter SHALL be 4 bits and SHALL never underflow or wrap.

Reset
REQ-028 When RST is high at an edge, SHALL set state to FREE, the counter to 0, ramload to 0, and the latched op/address to 0.
REQ-029 Reset SHALL abort any BUSY access with no array write.
REQ-030 SHALL NOT clear the array contents on reset.
REQ-031 The first post-reset request SHALL be sampled on the first edge with RST low.

Verification
REQ-032 Write then read, LAT=2: write 0xDEADBEEF to addr 0x40, then read 0x40 -> ramstate FREE,BUSY,BUSY,ACCESS for each access; ramload=0xDEADBEEF during the read ACCESS cycle.
REQ-033 Request change mid-BUSY: read 0x10, then switch to 0x14 after 1 BUSY cycle -> counter restarts; ACCESS occurs 2 cycles after the switch; ramload=mem[0x14].
REQ-034 Illegal requests: ramREN=ramWEN=1 -> ERROR held; misaligned addr 0x42 -> ERROR; addr 4*DEPTH -> ERROR; array unchanged in all cases; dropping the request -> FREE.
REQ-035 Abort: write 0x12345678 to 0x80 with the request dropped in BUSY -> FREE; a later read of 0x80 returns the old value.
REQ-036 Reset mid-BUSY: assert RST during BUSY of a write -> FREE next cycle, ramload=0, no write; array contents preserved.
REQ-037 Held read, LAT=1: hold a read of 0x20 for 6 cycles -> ramstate BUSY,ACCESS,BUSY,ACCESS,...; ramload stable at the correct value.
